// File: rtl/lsu_bus.sv
// lsu_bus: load/store unit bridging the single-cycle datapath to a
// req/ack data bus. One bus transaction per memory instruction; the PC is
// stalled until it completes. Load data is lane-extracted and extended.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses raise err
// instead of being silently aligned down).
module lsu_bus #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [1:0]  off_q;   // lane offset of the access in flight
  logic [2:0]  mask_q;  // funct3 of the access in flight

  logic        req;
  logic        illegal;
  logic [1:0]  off;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] lane;
  logic [31:0] ld_data;

  assign req   = rd_en | wr_en;
  assign stall = ((state == IDLE) && req) || (state == REQ);

  // Legality of the decoded access; illegal ones retire with err, no bus cycle
  always_comb begin
    illegal = 1'b0;
    if (rd_en && wr_en)
      illegal = 1'b1;
    else if (rd_en)
      illegal = (mask == 3'b011) || (mask[2:1] == 2'b11);
    else if (wr_en)
      illegal = mask[2] || (mask[1:0] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((mask[1:0] == 2'b01) && addr[0])
      illegal = 1'b1;
    if ((mask[1:0] == 2'b10) && (addr[1:0] != 2'b00))
      illegal = 1'b1;
`endif
  end

  // Lane offset, byte enables and replicated store data; sub-natural
  // address bits are dropped so the lanes always stay inside the word
  always_comb begin
    case (mask[1:0])
      2'b00: begin
        off     = addr[1:0];
        be_n    = 4'b0001 << off;
        wdata_n = {4{wdata[7:0]}};
      end
      2'b01: begin
        off     = {addr[1], 1'b0};
        be_n    = 4'b0011 << off;
        wdata_n = {2{wdata[15:0]}};
      end
      default: begin
        off     = 2'b00;
        be_n    = 4'b1111;
        wdata_n = wdata;
      end
    endcase
  end

  // Load extraction: shift the addressed lane down, then sign/zero extend
  always_comb begin
    lane = bus_rdata >> {off_q, 3'b000};
    case (mask_q[1:0])
      2'b00:   ld_data = mask_q[2] ? {24'h0, lane[7:0]}
                                   : {{24{lane[7]}}, lane[7:0]};
      2'b01:   ld_data = mask_q[2] ? {16'h0, lane[15:0]}
                                   : {{16{lane[15]}}, lane[15:0]};
      default: ld_data = bus_rdata;
    endcase
  end

  // Access FSM with registered bus outputs and done/err pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      off_q     <= '0;
      mask_q    <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (illegal) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= REQ;
              bus_req   <= 1'b1;
              bus_we    <= wr_en;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= be_n;
              bus_wdata <= wdata_n;
              off_q     <= off;
              mask_q    <= mask;
              tmo_cnt   <= '0;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we)
              rdata <= ld_data;
            state <= DONE;
            done  <= 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            bus_req <= 1'b0;
            state   <= DONE;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus.sv
// Bench for lsu_bus: directed cases plus randomized accesses checked against
// a byte-lane reference model.
module tb_lsu_bus;

  localparam int TMO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [2:0]  mask = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  lsu_bus #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .mask(mask),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .err(err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_rdata = '0;  // model of the architecturally held load result

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] m);
    return (m[1:0] == 2'd0) ? 1 : (m[1:0] == 2'd1) ? 2 : 4;
  endfunction

  // Natural-alignment offset: low bits below the access size are discarded
  function automatic int offs(input logic [2:0] m, input logic [31:0] a);
    int n = nbytes(m);
    return (int'(a[1:0]) / n) * n;
  endfunction

  function automatic bit legal(input bit rd, input bit wr, input logic [2:0] m,
                               input logic [31:0] a);
    int n = nbytes(m);
    if (rd && wr) return 1'b0;
    if (rd && (m == 3'd3 || m == 3'd6 || m == 3'd7)) return 1'b0;
    if (wr && m > 3'd2) return 1'b0;
    if (TRAP && (int'(a[1:0]) % n) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] m, input logic [31:0] a);
    int n = nbytes(m);
    return 4'(((1 << n) - 1) << offs(m, a));
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] m, input logic [31:0] d);
    int n = nbytes(m);
    logic [63:0] lm = (64'd1 << (8 * n)) - 64'd1;
    logic [63:0] w = '0;
    for (int k = 0; k < 4; k += n) w |= ({32'h0, d} & lm) << (8 * k);
    return w[31:0];
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] m, input logic [31:0] a,
                                         input logic [31:0] word);
    int n = nbytes(m);
    logic [63:0] lm = (64'd1 << (8 * n)) - 64'd1;
    logic [63:0] v  = ({32'h0, word} >> (8 * offs(m, a))) & lm;
    if (n < 4 && !m[2] && v[8 * n - 1]) v |= ~lm;
    return v[31:0];
  endfunction

  // One memory instruction, started at a negedge with the FSM idle.
  // waits < 0 means the slave never acks.
  task automatic access(input bit rd, input bit wr, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] word);
    bit ok, acked;
    rd_en = rd; wr_en = wr; mask = m; addr = a; wdata = wd;
    #1;
    chk("idle_stall", stall, 1);
    chk("idle_noreq", bus_req, 0);
    ok = legal(rd, wr, m, a);
    @(posedge clk); @(negedge clk);
    if (!ok) begin
      chk("ill_done", done, 1);
      chk("ill_err", err, 1);
      chk("ill_noreq", bus_req, 0);
      chk("ill_stall", stall, 0);
      chk("ill_rdata", rdata, m_rdata);
    end else begin
      acked = 1'b0;
      for (int i = 0; i < TMO; i++) begin
        chk("req", bus_req, 1);
        chk("req_stall", stall, 1);
        chk("req_done", done, 0);
        chk("req_addr", bus_addr, {a[31:2], 2'b00});
        chk("req_be", {28'h0, bus_be}, {28'h0, exp_be(m, a)});
        chk("req_we", bus_we, wr);
        if (wr) chk("req_wdata", bus_wdata, exp_wd(m, wd));
        bus_ack   = (i == waits);
        bus_rdata = (i == waits) ? word : $urandom;
        @(posedge clk); @(negedge clk);
        bus_ack = 1'b0;
        if (i == waits) begin acked = 1'b1; break; end
      end
      if (acked && rd) m_rdata = exp_ld(m, a, word);
      chk("fin_done", done, 1);
      chk("fin_err", err, !acked);
      chk("fin_noreq", bus_req, 0);
      chk("fin_stall", stall, 0);
      chk("fin_rdata", rdata, m_rdata);
    end
    rd_en = 1'b0; wr_en = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_done", done, 0);
    chk("post_err", err, 0);
    chk("post_stall", stall, 0);
  endtask

  initial begin
    int r, w;
    logic [2:0] m;
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", bus_req, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_be", {28'h0, bus_be}, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);

    // directed
    access(1, 0, 3'b010, 32'h104, 0, 0, 32'hDEADBEEF);          // LW
    access(1, 0, 3'b000, 32'h103, 0, 0, 32'h80FF1234);          // LB
    access(1, 0, 3'b100, 32'h103, 0, 1, 32'h80FF1234);          // LBU
    access(0, 1, 3'b001, 32'h22, 32'h0000ABCD, 3, 0);           // SH, 3 waits
    access(1, 0, 3'b101, 32'h2, 0, 2, 32'h9ABC5678);            // LHU
    access(1, 0, 3'b001, 32'h2, 0, 0, 32'h9ABC5678);            // LH
    access(1, 0, 3'b010, 32'h200, 0, -1, 0);                    // timeout
    access(1, 0, 3'b011, 32'h100, 0, 0, 0);                     // illegal mask
    access(1, 0, 3'b010, 32'h102, 0, 0, 32'h13572468);          // misaligned LW
    access(0, 1, 3'b100, 32'h40, 32'h11223344, 0, 0);           // illegal store mask
    access(1, 1, 3'b010, 32'h40, 32'h11223344, 0, 0);           // rd & wr
    access(0, 1, 3'b000, 32'h41, 32'hA5A5A5C3, TMO - 1, 0);     // SB, ack on last cycle

    // randomized
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      m = 3'($urandom_range(0, 7));
      w = $urandom_range(0, TMO);
      if (w == TMO) w = -1;
      access(r == 0 || r <= 5, r == 0 || r >= 6, m, $urandom, $urandom, w, $urandom);
    end

    // reset in the 2nd REQ cycle, then a late ack
    rd_en = 1'b1; mask = 3'b010; addr = 32'h300;
    @(posedge clk); @(negedge clk);
    chk("mid_req1", bus_req, 1);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    m_rdata = '0;
    chk("mid_noreq", bus_req, 0);
    chk("mid_rdata", rdata, m_rdata);
    chk("mid_done", done, 0);
    chk("mid_stall", stall, 1);
    rst_n = 1'b1; rd_en = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    #1;
    chk("mid_stall_idle", stall, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      chk("late_ack_done", done, 0);
      chk("late_ack_req", bus_req, 0);
      chk("late_ack_rdata", rdata, m_rdata);
    end
    bus_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
